// File: rtl/io_uart_tx.sv
// io_uart_tx: FIFO-buffered 8N1 UART transmitter with back-pressure and sticky overrun flag
module io_uart_tx #(
  parameter int FDEPTH_LOG2 = 4,
  parameter int BAUD_DIV    = 868
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           uart_io_char,
  input  logic                 uart_io_we,
  output logic                 uart_io_full,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_fifo_overrun,
  output logic [FDEPTH_LOG2:0] fifo_count
);
  localparam int AW    = FDEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << FDEPTH_LOG2;
  localparam int BW    = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BRELOAD = BW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr, count_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [2:0]    bidx, bidx_n;
  logic [7:0]    shift, shift_n;
  logic          push, pop, tx_n;

  assign uart_io_full = fifo_count == AW'(DEPTH);
  assign push         = uart_io_we && !uart_io_full;
  assign tx_busy      = state != IDLE;
  assign count_n      = fifo_count + AW'(push) - AW'(pop);
  assign tx_n         = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : 1'b1;

  // serializer next-state: pop on leaving IDLE, then count out start, 8 data and stop bits
  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    bidx_n  = bidx;
    shift_n = shift;
    pop     = 1'b0;
    case (state)
      IDLE: if (fifo_count != '0) begin
        pop     = 1'b1;
        shift_n = mem[rptr[FDEPTH_LOG2-1:0]];
        bcnt_n  = BRELOAD;
        state_n = START;
      end
      START: if (bcnt == '0) begin
        bcnt_n  = BRELOAD;
        bidx_n  = '0;
        state_n = DATA;
      end else bcnt_n = bcnt - BW'(1);
      DATA: if (bcnt == '0) begin
        bcnt_n  = BRELOAD;
        shift_n = shift >> 1;
        bidx_n  = bidx + 3'd1;
        state_n = bidx == 3'd7 ? STOP : DATA;
      end else bcnt_n = bcnt - BW'(1);
      STOP: if (bcnt == '0) state_n = IDLE;
      else bcnt_n = bcnt - BW'(1);
      default: state_n = IDLE;
    endcase
  end

  // state, pointers, occupancy, overrun and registered tx line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      bcnt            <= '0;
      bidx            <= '0;
      shift           <= '0;
      wptr            <= '0;
      rptr            <= '0;
      fifo_count      <= '0;
      tx_fifo_overrun <= 1'b0;
      tx              <= 1'b1;
    end else begin
      state           <= state_n;
      bcnt            <= bcnt_n;
      bidx            <= bidx_n;
      shift           <= shift_n;
      wptr            <= wptr + AW'(push);
      rptr            <= rptr + AW'(pop);
      fifo_count      <= count_n;
      tx_fifo_overrun <= tx_fifo_overrun | (uart_io_we & uart_io_full);
      tx              <= tx_n;
    end
  end

  // character storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wptr[FDEPTH_LOG2-1:0]] <= uart_io_char;
  end
endmodule
